// File: rtl/seg_capture.sv
// Receive side of a scanned 7-segment bus: synchronises the segment and digit-select
// lines, waits for a stable window, then decodes and stores one value per digit.
module seg_capture #(
  parameter int N_DIG      = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         i_seg,
  input  logic [N_DIG-1:0]   i_an,
  output logic [4*N_DIG-1:0] o_digit,
  output logic [N_DIG-1:0]   o_valid,
  output logic               o_update,
  output logic               o_err,
  output logic [2:0]         o_idx
);

  typedef enum logic [1:0] {IDLE, SETTLE, ACCEPT, HOLD} state_t;

  state_t state, state_next;
  logic [7:0] cnt, cnt_next;
  logic       accept;

  logic [7:0]       seg_s1, seg_s2, seg_prev;
  logic [N_DIG-1:0] an_s1, an_s2, an_prev;
  logic [N_DIG-1:0] an_low;
  logic             an_ok, changed;
  logic [2:0]       sel_idx;
  logic [4:0]       dec;

  // Decoded {ok, value} for the exact wire pattern (active-low segments).
  function automatic logic [4:0] decode(input logic [7:0] seg);
    case (seg)
      8'h02:   decode = {1'b1, 4'd0};
      8'h9F:   decode = {1'b1, 4'd1};
      8'h25:   decode = {1'b1, 4'd2};
      8'h0D:   decode = {1'b1, 4'd3};
      8'h99:   decode = {1'b1, 4'd4};
      8'h49:   decode = {1'b1, 4'd5};
      8'h41:   decode = {1'b1, 4'd6};
      8'h1F:   decode = {1'b1, 4'd7};
      8'h00:   decode = {1'b1, 4'd8};
      default: decode = {1'b0, 4'd0};
    endcase
  endfunction

  // Idle bus level is all-ones, so synchronisers and the previous sample reset there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1   <= '1;
      seg_s2   <= '1;
      seg_prev <= '1;
      an_s1    <= '1;
      an_s2    <= '1;
      an_prev  <= '1;
    end else begin
      // NOTE: non-blocking assignments make each stage take the old value of the one before it.
      seg_s1   <= i_seg;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      an_s1    <= i_an;
      an_s2    <= an_s1;
      an_prev  <= an_s2;
    end
  end

  assign an_low  = ~an_s2;
  assign an_ok   = (an_low != '0) && ((an_low & (an_low - N_DIG'(1))) == '0);
  assign changed = {an_s2, seg_s2} != {an_prev, seg_prev};
  assign dec     = decode(seg_s2);

  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < N_DIG; k++) begin
      if (!an_s2[k]) sel_idx = 3'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (an_ok) begin
          state_next = SETTLE;
          cnt_next   = 8'd1;
        end
      end
      SETTLE: begin
        if (changed) begin
          state_next = an_ok ? SETTLE : IDLE;
          cnt_next   = an_ok ? 8'd1 : 8'd0;
        end else if (cnt >= 8'(STABLE_CYC - 1)) begin
          // The sample completing the window decides here; the pulse is registered.
          state_next = ACCEPT;
          cnt_next   = 8'(STABLE_CYC);
          accept     = 1'b1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      ACCEPT, HOLD: begin
        if (changed) begin
          state_next = an_ok ? SETTLE : IDLE;
          cnt_next   = an_ok ? 8'd1 : 8'd0;
        end else begin
          state_next = HOLD;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the stored digit slots are reset too, since every output must read 0 in reset.
      o_digit  <= '0;
      o_valid  <= '0;
      o_update <= 1'b0;
      o_err    <= 1'b0;
      o_idx    <= '0;
    end else begin
      o_update <= 1'b0;
      o_err    <= 1'b0;
      if (accept) begin
        o_idx <= sel_idx;
        for (int k = 0; k < N_DIG; k++) begin
          if (sel_idx == 3'(k)) begin
            if (dec[4]) begin
              o_digit[4*k +: 4] <= dec[3:0];
              o_valid[k]        <= 1'b1;
            end else begin
              o_valid[k] <= 1'b0;
            end
          end
        end
        o_update <= dec[4];
        o_err    <= ~dec[4];
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Scoreboard bench for seg_capture: each driven pattern that should be accepted
// pushes its expected result and cycle; every output pulse pops and is compared.
module tb_seg_capture;

  localparam int N_DIG   = 4;
  localparam int LATENCY = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  i_seg;
  logic [3:0]  i_an;
  logic [15:0] o_digit;
  logic [3:0]  o_valid;
  logic        o_update, o_err;
  logic [2:0]  o_idx;

  seg_capture #(.N_DIG(N_DIG), .STABLE_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_seg(i_seg), .i_an(i_an),
    .o_digit(o_digit), .o_valid(o_valid), .o_update(o_update),
    .o_err(o_err), .o_idx(o_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    int         idx;
    logic [3:0] val;
    int         cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] exp_digit = '0;
  logic [3:0]  exp_valid = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit ref_decode(input logic [7:0] seg, output logic [3:0] val);
    ref_decode = 1'b1;
    case (seg)
      8'h02: val = 4'd0;  8'h9F: val = 4'd1;  8'h25: val = 4'd2;
      8'h0D: val = 4'd3;  8'h99: val = 4'd4;  8'h49: val = 4'd5;
      8'h41: val = 4'd6;  8'h1F: val = 4'd7;  8'h00: val = 4'd8;
      default: begin val = 4'd0; ref_decode = 1'b0; end
    endcase
  endfunction

  task automatic push_exp(input logic [3:0] an, input logic [7:0] seg, input int at);
    exp_t e;
    logic [3:0] v;
    e.err = !ref_decode(seg, v);
    e.val = v;
    e.idx = 0;
    for (int k = 0; k < N_DIG; k++) if (!an[k]) e.idx = k;
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply(input logic [3:0] an, input logic [7:0] seg, input int n, input bit exp_acc);
    i_an  = an;
    i_seg = seg;
    if (exp_acc) push_exp(an, seg, cyc + LATENCY);
    step(n);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digit"}, 32'(o_digit), 32'h0);
    check({tag, "_valid"}, 32'(o_valid), 32'h0);
    check({tag, "_update"}, 32'(o_update), 32'h0);
    check({tag, "_err"}, 32'(o_err), 32'h0);
    check({tag, "_idx"}, 32'(o_idx), 32'h0);
  endtask

  // Monitor: any pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (o_update || o_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, o_update, o_err}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.err) begin
          exp_valid[e.idx] = 1'b0;
        end else begin
          exp_digit[4*e.idx +: 4] = e.val;
          exp_valid[e.idx] = 1'b1;
        end
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("update", 32'(o_update), 32'(!e.err));
        check("err", 32'(o_err), 32'(e.err));
        check("idx", 32'(o_idx), 32'(e.idx));
        check("digit", 32'(o_digit), 32'(exp_digit));
        check("valid", 32'(o_valid), 32'(exp_valid));
      end
    end
  end

  initial begin
    int r;
    rst_n = 1'b0;
    i_an  = 4'b1110;
    i_seg = 8'h0D;
    step(3);
    check_zero("reset");

    // Release with an active scan already on the pins: single digit 3 at position 0.
    rst_n = 1'b1;
    r = cyc;
    push_exp(4'b1110, 8'h0D, r + LATENCY);
    step(10);
    check("single_valid", 32'(o_valid), 32'h1);

    // Full scan, positions 3..0 showing 8,0,7,1.
    apply(4'b0111, 8'h00, 6, 1'b1);
    apply(4'b1011, 8'h02, 6, 1'b1);
    apply(4'b1101, 8'h1F, 6, 1'b1);
    apply(4'b1110, 8'h9F, 6, 1'b1);
    step(LATENCY);
    check("scan_digit", 32'(o_digit), 32'h8071);
    check("scan_valid", 32'(o_valid), 32'hF);

    // One-cycle glitch restarts the window; a single accept of 4 follows.
    apply(4'b1101, 8'h99, 3, 1'b0);
    apply(4'b1101, 8'h98, 1, 1'b0);
    apply(4'b1101, 8'h99, 10, 1'b1);
    check("glitch_digit", 32'(o_digit), 32'h8041);

    // Unknown code at position 2: error pulse, valid bit cleared, value kept.
    apply(4'b1011, 8'hFF, 10, 1'b1);
    check("bad_digit", 32'(o_digit), 32'h8041);
    check("bad_valid", 32'(o_valid), 32'hB);

    // Multiple or no digit selects: nothing captured.
    apply(4'b1100, 8'h0D, 20, 1'b0);
    apply(4'b1111, 8'h0D, 20, 1'b0);
    check("multi_digit", 32'(o_digit), 32'h8041);
    check("multi_valid", 32'(o_valid), 32'hB);
    check("multi_idx", 32'(o_idx), 32'h2);

    // Change lands on the sample that would have completed the window.
    apply(4'b1110, 8'h49, 3, 1'b0);
    apply(4'b1110, 8'h41, 10, 1'b1);
    check("window_digit", 32'(o_digit), 32'h8046);

    // Reset mid-window clears everything; capture restarts after release.
    apply(4'b1101, 8'h25, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_digit = '0;
    exp_valid = '0;
    check_zero("midreset");
    step(2);
    rst_n = 1'b1;
    r = cyc;
    push_exp(4'b1101, 8'h25, r + LATENCY);
    step(10);
    check("post_reset_digit", 32'(o_digit), 32'h0020);
    check("post_reset_valid", 32'(o_valid), 32'h2);

    step(5);
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
